// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings, widths, latencies and FSM state type for
//               the E-stage multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int MDU_W              = 32;
    localparam int MDU_MULT_CYCLES    = 5;
    localparam int MDU_DIV_CYCLES     = 10;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic mdu_is_mult(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_core.sv
// ============================================================================
// Module      : mdu_core
// Description : Combinational 64-bit product and quotient/remainder datapath
//               with a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_core
    import mdu_pkg::*;
(
    input  logic [2:0]       i_op,
    input  logic [MDU_W-1:0] i_a,
    input  logic [MDU_W-1:0] i_b,
    output logic [MDU_W-1:0] o_hi,
    output logic [MDU_W-1:0] o_lo,
    output logic             o_div_zero
);

    logic signed [63:0]      w_prod_s;
    logic [63:0]             w_prod_u;
    logic                    w_b_zero;
    logic                    w_ovf;
    logic [MDU_W-1:0]        w_dsor_s;
    logic [MDU_W-1:0]        w_dsor_u;
    logic signed [MDU_W-1:0] w_quo_s;
    logic signed [MDU_W-1:0] w_rem_s;
    logic [MDU_W-1:0]        w_quo_u;
    logic [MDU_W-1:0]        w_rem_u;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Zero and MIN/-1 divisors are replaced by 1: the zero case is never
    // committed, and dividing MIN by 1 yields exactly the overflow result.
    assign w_b_zero = (i_b == '0);
    assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_dsor_s = (w_b_zero || w_ovf) ? 32'd1 : i_b;
    assign w_dsor_u = w_b_zero ? 32'd1 : i_b;

    assign w_quo_s = $signed(i_a) / $signed(w_dsor_s);
    assign w_rem_s = $signed(i_a) % $signed(w_dsor_s);
    assign w_quo_u = i_a / w_dsor_u;
    assign w_rem_u = i_a % w_dsor_u;

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        case (i_op)
            MDU_OP_MULT:  {o_hi, o_lo} = w_prod_s;
            MDU_OP_MULTU: {o_hi, o_lo} = w_prod_u;
            MDU_OP_DIV:   begin o_hi = w_rem_s; o_lo = w_quo_s; end
            MDU_OP_DIVU:  begin o_hi = w_rem_u; o_lo = w_quo_u; end
            default:      begin o_hi = '0; o_lo = '0; end
        endcase
    end

    assign o_div_zero = mdu_is_div(i_op) && w_b_zero;

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers; result
//               is latched at issue and committed after a fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [MDU_W-1:0] A,
    input  logic [MDU_W-1:0] B,
    output logic             busy,
    output logic [MDU_W-1:0] hi,
    output logic [MDU_W-1:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    mdu_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [MDU_W-1:0]   r_shadow_hi;
    logic [MDU_W-1:0]   r_shadow_lo;
    logic               r_commit;
    logic               r_busy;
    logic [MDU_W-1:0]   r_hi;
    logic [MDU_W-1:0]   r_lo;

    logic [MDU_W-1:0]   w_res_hi;
    logic [MDU_W-1:0]   w_res_lo;
    logic               w_div_zero;

    mdu_core u_core (
        .i_op       (op),
        .i_a        (A),
        .i_b        (B),
        .o_hi       (w_res_hi),
        .o_lo       (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= MDU_IDLE;
            r_cnt       <= '0;
            r_shadow_hi <= '0;
            r_shadow_lo <= '0;
            r_commit    <= 1'b0;
            r_busy      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (start) begin
                        if (mdu_is_mult(op) || mdu_is_div(op)) begin
                            r_shadow_hi <= w_res_hi;
                            r_shadow_lo <= w_res_lo;
                            r_commit    <= !w_div_zero;
                            r_cnt       <= mdu_is_mult(op) ? c_MULT_LD : c_DIV_LD;
                            r_busy      <= 1'b1;
                            r_state     <= MDU_RUN;
                        end else if (op == MDU_OP_MTHI) begin
                            r_hi <= A;
                        end else if (op == MDU_OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                MDU_RUN: begin
                    // Starts arriving here are dropped: the pipeline stalls them.
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_busy  <= 1'b0;
                        r_state <= MDU_IDLE;
                        if (r_commit) begin
                            r_hi <= r_shadow_hi;
                            r_lo <= r_shadow_lo;
                        end
                    end
                end
                default: begin
                    r_state <= MDU_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire
